gpio_in_filter_irq: RTL and testbench
=====================================

// Module: gpio_in_filter_irq
// PURPOSE
// - Input conditioning and interrupt stage for GPIO pin levels. Sits downstream of the gpio pin-sense path.
// - Takes the raw per-bit pin levels (pin_w of the gpio block), synchronises and debounces each bit, and detects edges.
// - Latches edges into interrupt flags and drives one irq line to the CPU.
// - Shares the gpio memory-mapped bus: same addr/data/we signals, its own address window 131..134.
// PARAMETERS
// WIDTH       32   number of pin bits handled (1..32)
// DEB_CYCLES  4    consecutive stable clocks required before pin_filt follows (1..255)
// CNT_W       8    debounce counter width per bit; DEB_CYCLES <= 2**CNT_W-1
// IER_ADDR    131  interrupt enable reg (R/W)
// IFR_ADDR    132  interrupt flag reg (R, write-1-to-clear)
// EDGE_ADDR   133  edge select reg (R/W): bit=1 rising, bit=0 falling
// PINF_ADDR   134  filtered pin level (read-only)
// PORTS
// clk         in   1      system clock, rising edge
// arst_n      in   1      asynchronous reset, active-low
// pin_raw     in   WIDTH  raw pin levels, asynchronous to clk
// bus_addr    in   32     word address, shared with gpio
// bus_i_data  in   32     write data
// we          in   1      write strobe, sampled on rising clk
// bus_o_data  out  32     read data, combinational on bus_addr; 0 outside own window
// pin_filt    out  WIDTH  debounced pin levels
// irq         out  1      |(IFR & IER)
// BEHAVIOUR
// - Reset (arst_n=0, async): sync flops, counters, pin_filt, IER, IFR, EDGE <= 0. irq=0; bus_o_data=0 unless a readable address is presented.
// - Reset mid-debounce: partial count is discarded.
// - Sync: 2 flops per bit (s1 <= pin_raw, s2 <= s1). s2 is the only value used downstream.
// - Debounce, per bit, each rising edge:
//   s2==filt                 -> cnt <= 0
//   s2!=filt, cnt<DEB-1      -> cnt <= cnt+1
//   s2!=filt, cnt==DEB-1     -> filt <= s2, cnt <= 0
// - Latency: pin_raw new at edge 0 -> pin_filt changes at edge 1+DEB_CYCLES.
// - A glitch shorter than DEB_CYCLES clocks at s2 never reaches pin_filt.
// - Event: on the edge where filt changes 0->1 and EDGE[i]=1, or 1->0 and EDGE[i]=0 -> IFR[i] <= 1 on that same edge.
// - IFR flags set regardless of IER. IER only masks irq.
// - irq is combinational from the IFR/IER flops, so it rises in the cycle after the flag-setting edge. No pulse stretching.
// - Writes (we=1, rising edge):
//   IER, EDGE <= bus_i_data[WIDTH-1:0]
//   IFR      <= IFR & ~bus_i_data (W1C)
//   PINF and all other addresses: ignored, no side effects (other regs kept)
// - Simultaneous W1C and new event on the same bit, same edge: set wins, IFR[i]=1.
// - Changing EDGE[i] does not create an event. Only filt transitions do.
// - Read mux, combinational on bus_addr: 131 IER, 132 IFR, 133 EDGE, 134 pin_filt.
//   Bits [31:WIDTH] read 0. Any other address reads 0, so the result can be OR-ed with the gpio read data.
// - After reset, a pin held high yields a 0->1 filt transition. No IFR set, because EDGE=0 (falling) after reset.
// TESTING
// - Reset: arst_n low mid-count, pin_raw=all 1 -> all outputs 0; after release, pin_filt=FFFFFFFF at edge 1+4; IFR=0.
// - Debounce latency: DEB=4, pin_raw[0] 0->1 before edge 0 -> pin_filt[0]=1 after edge 5, not after edge 4.
// - Glitch: pin_raw[3]=1 for 3 clocks then 0 -> pin_filt[3] stays 0, cnt back to 0, IFR=0.
// - Edge/irq: EDGE=1, IER=1, pin_raw[0] rises -> IFR=00000001 on filt edge, irq=1 next cycle.
//   Write 1 to 132 -> IFR=0, irq=0. With IER=0: flag set, irq stays 0.
// - W1C collision: W1C of bit 0 on the same edge as a new bit-0 event -> IFR[0]=1.
// - Bus: write 0xA5 to 130 -> own regs unchanged. Read 129/135 -> 0. Read 134 -> pin_filt. WIDTH=8: upper read bits 0.

Source files
------------

// File: rtl/gpio_in_filter_irq.sv
`default_nettype none
// ============================================================================
// Module   : gpio_in_filter_irq
// Brief    : GPIO input synchroniser, per-bit debounce, edge-to-flag latch and
//            irq generation behind a small bus-mapped register window.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_in_filter_irq #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned CNT_W      = 8,
    parameter logic [31:0] IER_ADDR   = 32'd131,
    parameter logic [31:0] IFR_ADDR   = 32'd132,
    parameter logic [31:0] EDGE_ADDR  = 32'd133,
    parameter logic [31:0] PINF_ADDR  = 32'd134
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [WIDTH-1:0] pin_raw,
    input  logic [31:0]      bus_addr,
    input  logic [31:0]      bus_i_data,
    input  logic             we,
    output logic [31:0]      bus_o_data,
    output logic [WIDTH-1:0] pin_filt,
    output logic             irq
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_filt;
    logic [WIDTH-1:0] r_ier;
    logic [WIDTH-1:0] r_ifr;
    logic [WIDTH-1:0] r_edge;
    logic [WIDTH-1:0] w_done;
    logic [WIDTH-1:0] w_event;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_rd_field;
    logic             w_wr_ier;
    logic             w_wr_ifr;
    logic             w_wr_edge;

    assign w_wdata   = bus_i_data[WIDTH-1:0];
    assign w_wr_ier  = we && (bus_addr == IER_ADDR);
    assign w_wr_ifr  = we && (bus_addr == IFR_ADDR);
    assign w_wr_edge = we && (bus_addr == EDGE_ADDR);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= pin_raw;
            r_s2 <= r_s1;
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic [CNT_W-1:0] r_cnt;

        // Last stable cycle reached: the filtered level flips on this edge.
        assign w_done[gi] = (r_s2[gi] != r_filt[gi]) && (r_cnt == C_CNT_LAST);

        always_ff @(posedge clk or negedge arst_n) begin
            if (!arst_n) begin
                r_cnt <= '0;
            end else if ((r_s2[gi] == r_filt[gi]) || w_done[gi]) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + C_CNT_ONE;
            end
        end
    end

    // A completed bit always moves filt towards s2, so the new level equals s2.
    assign w_event = w_done & ~(r_s2 ^ r_edge);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_filt <= '0;
            r_ier  <= '0;
            r_edge <= '0;
            r_ifr  <= '0;
        end else begin
            r_filt <= r_filt ^ w_done;
            if (w_wr_ier) begin
                r_ier <= w_wdata;
            end
            if (w_wr_edge) begin
                r_edge <= w_wdata;
            end
            // New events OR in after the clear so a same-edge set wins.
            r_ifr <= (w_wr_ifr ? (r_ifr & ~w_wdata) : r_ifr) | w_event;
        end
    end

    always_comb begin
        w_rd_field = '0;
        bus_o_data = '0;
        case (bus_addr)
            IER_ADDR:  w_rd_field = r_ier;
            IFR_ADDR:  w_rd_field = r_ifr;
            EDGE_ADDR: w_rd_field = r_edge;
            PINF_ADDR: w_rd_field = r_filt;
            default:   w_rd_field = '0;
        endcase
        bus_o_data[WIDTH-1:0] = w_rd_field;
    end

    assign pin_filt = r_filt;
    assign irq      = |(r_ifr & r_ier);

endmodule
`default_nettype wire

// File: tb/tb_gpio_in_filter_irq.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_in_filter_irq
// Brief    : Directed bench for gpio_in_filter_irq (32-bit and 8-bit instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_in_filter_irq;

    logic        clk = 1'b0;
    logic        arst_n;
    logic [31:0] pin_raw;
    logic [31:0] bus_addr;
    logic [31:0] bus_i_data;
    logic        we;
    logic [31:0] bus_o_data;
    logic [31:0] pin_filt;
    logic        irq;
    logic [7:0]  pin8;
    logic [7:0]  filt8;
    logic [31:0] rdata8;
    logic        irq8;

    int total = 0;
    int bad   = 0;

    always #10 clk = ~clk;

    gpio_in_filter_irq dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .pin_raw    (pin_raw),
        .bus_addr   (bus_addr),
        .bus_i_data (bus_i_data),
        .we         (we),
        .bus_o_data (bus_o_data),
        .pin_filt   (pin_filt),
        .irq        (irq)
    );

    gpio_in_filter_irq #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .arst_n     (arst_n),
        .pin_raw    (pin8),
        .bus_addr   (bus_addr),
        .bus_i_data (bus_i_data),
        .we         (we),
        .bus_o_data (rdata8),
        .pin_filt   (filt8),
        .irq        (irq8)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [31:0] raddr;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs [9];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp);
        bus_addr = addr;
        #1;
        check(name, bus_o_data, exp);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus_addr   = addr;
        bus_i_data = data;
        we         = 1'b1;
        step(1);
        we         = 1'b0;
        bus_i_data = '0;
    endtask

    initial begin
        // Starting state for the table: IER=0, EDGE=0, IFR=0, filt=0, pins=0.
        vecs[0] = '{1'b1, 32'd133, 32'h1,        32'd133, 32'h1, 1'b0};
        vecs[1] = '{1'b1, 32'd131, 32'h1,        32'd131, 32'h1, 1'b0};
        vecs[2] = '{1'b1, 32'd130, 32'hA5,       32'd131, 32'h1, 1'b0};
        vecs[3] = '{1'b0, 32'd0,   32'h0,        32'd133, 32'h1, 1'b0};
        vecs[4] = '{1'b0, 32'd0,   32'h0,        32'd132, 32'h0, 1'b0};
        vecs[5] = '{1'b0, 32'd0,   32'h0,        32'd129, 32'h0, 1'b0};
        vecs[6] = '{1'b0, 32'd0,   32'h0,        32'd135, 32'h0, 1'b0};
        vecs[7] = '{1'b1, 32'd134, 32'hFFFFFFFF, 32'd134, 32'h0, 1'b0};
        vecs[8] = '{1'b1, 32'd132, 32'hFFFFFFFF, 32'd131, 32'h1, 1'b0};

        arst_n     = 1'b0;
        pin_raw    = '1;
        pin8       = '0;
        we         = 1'b0;
        bus_addr   = '0;
        bus_i_data = '0;
        step(2);
        arst_n = 1'b1;
        step(3);
        arst_n = 1'b0;
        #1;
        check("rst_pin_filt", pin_filt, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        for (int a = 131; a <= 134; a++) begin
            rd($sformatf("rst_rd%0d", a), 32'(a), 32'h0);
        end
        step(1);
        arst_n = 1'b1;
        step(5);
        check("rst_filt_early", pin_filt, 32'h0);
        step(1);
        check("rst_filt_edge5", pin_filt, 32'hFFFFFFFF);
        rd("rst_ifr", 32'd132, 32'h0);

        pin_raw = '0;
        step(6);
        check("fall_filt", pin_filt, 32'h0);
        rd("fall_ifr", 32'd132, 32'hFFFFFFFF);
        check("fall_irq_masked", {31'b0, irq}, 32'h0);
        wr(32'd132, 32'hFFFFFFFF);
        rd("fall_ifr_clr", 32'd132, 32'h0);

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].we) wr(vecs[i].waddr, vecs[i].wdata);
            else step(1);
            rd($sformatf("vec%0d_rd", i), vecs[i].raddr, vecs[i].exp_rd);
            check($sformatf("vec%0d_irq", i), {31'b0, irq}, {31'b0, vecs[i].exp_irq});
        end

        // Debounce latency on bit 0 with EDGE=1, IER=1.
        pin_raw = 32'h1;
        step(5);
        check("lat_filt_edge4", pin_filt, 32'h0);
        rd("lat_ifr_early", 32'd132, 32'h0);
        step(1);
        check("lat_filt_edge5", pin_filt, 32'h1);
        rd("lat_ifr", 32'd132, 32'h1);
        check("lat_irq", {31'b0, irq}, 32'h1);
        wr(32'd132, 32'h1);
        rd("lat_ifr_clr", 32'd132, 32'h0);
        check("lat_irq_clr", {31'b0, irq}, 32'h0);

        // Three-clock glitch on bit 3 with a rising edge armed on it.
        wr(32'd133, 32'h9);
        pin_raw = 32'h9;
        step(3);
        pin_raw = 32'h1;
        step(10);
        check("glitch_filt", pin_filt, 32'h1);
        rd("glitch_ifr", 32'd132, 32'h0);

        // Edge-select change alone, then W1C colliding with a bit-0 fall.
        wr(32'd133, 32'h8);
        rd("edge_chg_no_event", 32'd132, 32'h0);
        pin_raw = 32'h0;
        step(5);
        check("coll_filt_before", pin_filt, 32'h1);
        rd("coll_ifr_before", 32'd132, 32'h0);
        wr(32'd132, 32'h1);
        check("coll_filt_after", pin_filt, 32'h0);
        rd("coll_ifr_set_wins", 32'd132, 32'h1);
        check("coll_irq", {31'b0, irq}, 32'h1);

        // 8-bit instance: upper read bits zero, filtered level and flags.
        wr(32'd131, 32'hFFFFFFFF);
        rd("ier32_full", 32'd131, 32'hFFFFFFFF);
        check("ier8_upper_zero", rdata8, 32'h000000FF);
        pin8 = 8'hFF;
        step(6);
        bus_addr = 32'd134;
        #1;
        check("w8_pin_filt", {24'b0, filt8}, 32'h000000FF);
        check("w8_rd_pinf", rdata8, 32'h000000FF);
        bus_addr = 32'd132;
        #1;
        check("w8_ifr", rdata8, 32'h00000008);
        check("w8_irq", {31'b0, irq8}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
